// File: rtl/write_buffer.sv
// Write-back buffer between L2 and pmem: absorbs dirty-line evictions into a FIFO,
// serves read hits from buffered lines, forwards misses ahead of background drains.
module write_buffer #(
  parameter int LINE_W = 128,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   l2_cyc,
  input  logic                   l2_stb,
  input  logic                   l2_we,
  input  logic [ADDR_W-1:0]      l2_adr,
  input  logic [LINE_W-1:0]      l2_dat_m,
  output logic [LINE_W-1:0]      l2_dat_s,
  output logic                   l2_ack,
  output logic                   l2_rty,
  output logic                   mem_cyc,
  output logic                   mem_stb,
  output logic                   mem_we,
  output logic [ADDR_W-1:0]      mem_adr,
  output logic [LINE_W-1:0]      mem_dat_m,
  output logic [LINE_W/8-1:0]    mem_sel,
  input  logic [LINE_W-1:0]      mem_dat_s,
  input  logic                   mem_ack,
  input  logic                   mem_rty,
  input  logic                   flush,
  output logic                   flush_done,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, RD, RESP, WR} state_t;

  state_t            state_r;
  logic [DEPTH-1:0]  valid_r;
  logic [ADDR_W-1:0] adr_r [DEPTH];
  logic [LINE_W-1:0] dat_r [DEPTH];
  logic [PW-1:0]     head_r;
  logic [PW-1:0]     tail_r;
  logic [CW-1:0]     count_r;

  logic          req_s, wr_req_s, rd_req_s, in_flight_s, full_s;
  logic          rd_hit_s, coal_hit_s, push_s, coal_s, pop_s, rd_miss_s, hit_ack_s;
  logic [PW-1:0] idx_s, rd_idx_s, coal_idx_s;
  logic [CW-1:0] nxt_count_s;

  assign mem_sel = {(LINE_W/8){1'b1}};
  assign count   = count_r;

  // Request decode and oldest-to-youngest match search (last match wins = youngest).
  always_comb begin
    req_s       = l2_cyc & l2_stb & ~l2_ack;
    wr_req_s    = req_s & l2_we;
    rd_req_s    = req_s & ~l2_we;
    in_flight_s = (state_r == WR);
    full_s      = (count_r == CW'(DEPTH));
    idx_s       = head_r;
    rd_hit_s    = 1'b0;
    rd_idx_s    = head_r;
    coal_hit_s  = 1'b0;
    coal_idx_s  = head_r;
    for (int k = 0; k < DEPTH; k++) begin
      idx_s = head_r + PW'(k);
      if (valid_r[idx_s] && (adr_r[idx_s] == l2_adr)) begin
        rd_hit_s = 1'b1;
        rd_idx_s = idx_s;
        if (!(in_flight_s && (idx_s == head_r))) begin
          coal_hit_s = 1'b1;
          coal_idx_s = idx_s;
        end else begin
          coal_hit_s = coal_hit_s;
        end
      end else begin
        rd_hit_s = rd_hit_s;
      end
    end
    push_s      = wr_req_s & ~coal_hit_s & ~full_s;
    coal_s      = wr_req_s & coal_hit_s;
    l2_rty      = wr_req_s & ~coal_hit_s & full_s;
    rd_miss_s   = rd_req_s & ~rd_hit_s;
    hit_ack_s   = rd_req_s & rd_hit_s;
    pop_s       = in_flight_s & mem_ack & ~mem_rty;
    nxt_count_s = count_r + CW'(push_s) - CW'(pop_s);
  end

  // Line storage: allocate at tail or coalesce into the youngest non-in-flight match.
  always_ff @(posedge clk) begin
    if (push_s) begin
      adr_r[tail_r] <= l2_adr;
      dat_r[tail_r] <= l2_dat_m;
    end else if (coal_s) begin
      dat_r[coal_idx_s] <= l2_dat_m;
    end
  end

  // FIFO bookkeeping, L2 responses and the pmem FSM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      valid_r    <= '0;
      head_r     <= '0;
      tail_r     <= '0;
      count_r    <= '0;
      l2_ack     <= 1'b0;
      l2_dat_s   <= '0;
      mem_cyc    <= 1'b0;
      mem_stb    <= 1'b0;
      mem_we     <= 1'b0;
      mem_adr    <= '0;
      mem_dat_m  <= '0;
      flush_done <= 1'b0;
    end else begin
      l2_ack     <= push_s | coal_s | hit_ack_s;
      count_r    <= nxt_count_s;
      flush_done <= flush & (nxt_count_s == '0);
      if (hit_ack_s) begin
        l2_dat_s <= dat_r[rd_idx_s];
      end
      if (push_s) begin
        valid_r[tail_r] <= 1'b1;
        tail_r          <= tail_r + PW'(1);
      end
      if (pop_s) begin
        valid_r[head_r] <= 1'b0;
        head_r          <= head_r + PW'(1);
      end
      case (state_r)
        IDLE: begin
          if (rd_miss_s) begin
            state_r <= RD;
            mem_cyc <= 1'b1;
            mem_stb <= 1'b1;
            mem_we  <= 1'b0;
            mem_adr <= l2_adr;
          end else if (count_r != '0) begin
            state_r <= WR;
            mem_cyc <= 1'b1;
            mem_stb <= 1'b1;
            mem_we  <= 1'b1;
            mem_adr <= adr_r[head_r];
            // a coalesce into the head this same cycle must not be lost by the drain
            mem_dat_m <= (coal_s && (coal_idx_s == head_r)) ? l2_dat_m : dat_r[head_r];
          end
        end
        RD: begin
          if (!mem_rty && mem_ack) begin
            state_r  <= RESP;
            mem_cyc  <= 1'b0;
            mem_stb  <= 1'b0;
            l2_ack   <= 1'b1;
            l2_dat_s <= mem_dat_s;
          end
        end
        RESP: begin
          state_r <= IDLE;
        end
        WR: begin
          if (!mem_rty && mem_ack) begin
            state_r <= IDLE;
            mem_cyc <= 1'b0;
            mem_stb <= 1'b0;
            mem_we  <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          mem_cyc <= 1'b0;
          mem_stb <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_write_buffer.sv
// Directed bench for write_buffer: a reset/single-drain vector table, then
// hand-written sequences for full/coalesce, read hit, read-miss priority, rty and flush.
module tb_write_buffer;

  localparam logic [127:0] D1 = {4{32'h1111_0001}};
  localparam logic [127:0] D2 = {4{32'h2222_0002}};
  localparam logic [127:0] D3 = {4{32'h3333_0003}};
  localparam logic [127:0] D4 = {4{32'h4444_0004}};
  localparam logic [127:0] D5 = {4{32'h5555_0005}};
  localparam logic [127:0] D6 = {4{32'h6666_0006}};
  localparam logic [127:0] D7 = {4{32'h7777_0007}};
  localparam logic [127:0] D8 = {4{32'h8888_0008}};
  localparam logic [127:0] D9 = {4{32'h9999_0009}};
  localparam logic [127:0] DA = {4{32'hAAAA_000A}};
  localparam logic [127:0] DB = {4{32'hBBBB_000B}};
  localparam logic [127:0] DC = {4{32'hCCCC_000C}};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         l2_cyc = 1'b0, l2_stb = 1'b0, l2_we = 1'b0;
  logic [15:0]  l2_adr = 16'h0;
  logic [127:0] l2_dat_m = 128'h0;
  logic [127:0] l2_dat_s;
  logic         l2_ack, l2_rty;
  logic         mem_cyc, mem_stb, mem_we;
  logic [15:0]  mem_adr;
  logic [127:0] mem_dat_m;
  logic [15:0]  mem_sel;
  logic [127:0] mem_dat_s = 128'h0;
  logic         mem_ack = 1'b0, mem_rty = 1'b0, flush = 1'b0;
  logic         flush_done;
  logic [2:0]   count;

  int checks = 0;
  int failures = 0;

  write_buffer #(.LINE_W(128), .ADDR_W(16), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .l2_cyc(l2_cyc), .l2_stb(l2_stb), .l2_we(l2_we), .l2_adr(l2_adr),
    .l2_dat_m(l2_dat_m), .l2_dat_s(l2_dat_s), .l2_ack(l2_ack), .l2_rty(l2_rty),
    .mem_cyc(mem_cyc), .mem_stb(mem_stb), .mem_we(mem_we), .mem_adr(mem_adr),
    .mem_dat_m(mem_dat_m), .mem_sel(mem_sel), .mem_dat_s(mem_dat_s),
    .mem_ack(mem_ack), .mem_rty(mem_rty),
    .flush(flush), .flush_done(flush_done), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rstn, stb, we, mack, fl;
    logic [15:0]  adr;
    logic [127:0] dat;
    logic         e_ack, e_cyc, e_we, e_fdone;
    logic [2:0]   e_cnt;
    logic [15:0]  e_madr;
    logic [127:0] e_mdat;
  } vec_t;

  vec_t vecs [11];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic l2_write(input logic [15:0] a, input logic [127:0] d, input logic [2:0] exp_cnt);
    l2_cyc = 1'b1; l2_stb = 1'b1; l2_we = 1'b1; l2_adr = a; l2_dat_m = d;
    tick();
    chk("wr_ack", 128'(l2_ack), 128'd1);
    chk("wr_count", 128'(count), 128'(exp_cnt));
    l2_cyc = 1'b0; l2_stb = 1'b0;
    tick();
    chk("wr_ack_drop", 128'(l2_ack), 128'd0);
  endtask

  task automatic drain_one(input logic [15:0] a, input logic [127:0] d);
    int n = 0;
    while (!(mem_cyc === 1'b1 && mem_we === 1'b1) && n < 8) begin
      tick();
      n++;
    end
    chk("drain_issue", 128'(mem_cyc & mem_we), 128'd1);
    chk("drain_adr", 128'(mem_adr), 128'(a));
    chk("drain_dat", mem_dat_m, d);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("drain_cyc_drop", 128'(mem_cyc), 128'd0);
  endtask

  initial begin
    //         rstn stb  we   mack fl    adr      dat  ack  cyc  we  fdone cnt     madr      mdat
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0,  D1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0,  128'h0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0,  D1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0,  128'h0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0,  D1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 16'h0,  128'h0};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h40, D1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 16'h0,  128'h0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0,  D2, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1, 16'h40, D1};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0,  D2, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1, 16'h40, D1};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0,  D2, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1, 16'h40, D1};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0,  D2, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1, 16'h40, D1};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0,  D2, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1, 16'h40, D1};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0,  D2, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0,  128'h0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0,  D2, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0,  128'h0};

    // Reset, single write accept, 5-cycle pmem drain
    for (int i = 0; i < 11; i++) begin
      rst_n = vecs[i].rstn; l2_cyc = vecs[i].stb; l2_stb = vecs[i].stb; l2_we = vecs[i].we;
      l2_adr = vecs[i].adr; l2_dat_m = vecs[i].dat; mem_ack = vecs[i].mack; flush = vecs[i].fl;
      tick();
      chk($sformatf("v%0d_ack", i), 128'(l2_ack), 128'(vecs[i].e_ack));
      chk($sformatf("v%0d_cyc", i), 128'(mem_cyc), 128'(vecs[i].e_cyc));
      chk($sformatf("v%0d_count", i), 128'(count), 128'(vecs[i].e_cnt));
      chk($sformatf("v%0d_fdone", i), 128'(flush_done), 128'(vecs[i].e_fdone));
      if (vecs[i].e_cyc) begin
        chk($sformatf("v%0d_mwe", i), 128'(mem_we), 128'(vecs[i].e_we));
        chk($sformatf("v%0d_madr", i), 128'(mem_adr), 128'(vecs[i].e_madr));
        chk($sformatf("v%0d_mdat", i), mem_dat_m, vecs[i].e_mdat);
      end
    end
    mem_ack = 1'b0;
    chk("mem_sel", 128'(mem_sel), 128'hFFFF);

    // Fill to DEPTH with pmem stalled, full retry, coalesce into a non-head line
    l2_write(16'h0100, D2, 3'd1);
    l2_write(16'h0200, D3, 3'd2);
    l2_write(16'h0300, D4, 3'd3);
    l2_write(16'h0400, D5, 3'd4);
    l2_cyc = 1'b1; l2_stb = 1'b1; l2_we = 1'b1; l2_adr = 16'h0500; l2_dat_m = D6;
    #1;
    chk("full_rty", 128'(l2_rty), 128'd1);
    tick();
    chk("full_no_ack", 128'(l2_ack), 128'd0);
    chk("full_count", 128'(count), 128'd4);
    l2_adr = 16'h0100;
    #1;
    chk("inflight_head_rty", 128'(l2_rty), 128'd1);
    l2_cyc = 1'b0; l2_stb = 1'b0;
    tick();
    l2_write(16'h0300, D9, 3'd4);
    drain_one(16'h0100, D2);
    drain_one(16'h0200, D3);
    drain_one(16'h0300, D9);
    drain_one(16'h0400, D5);
    chk("fill_drained_count", 128'(count), 128'd0);

    // Read hit on in-flight head, then youngest-match selection
    l2_write(16'h0040, D1, 3'd1);
    l2_cyc = 1'b1; l2_stb = 1'b1; l2_we = 1'b0; l2_adr = 16'h0040;
    tick();
    chk("hit_ack", 128'(l2_ack), 128'd1);
    chk("hit_dat", l2_dat_s, D1);
    chk("hit_no_pmem_read", 128'(mem_we), 128'd1);
    chk("hit_madr", 128'(mem_adr), 128'h0040);
    l2_cyc = 1'b0; l2_stb = 1'b0;
    tick();
    l2_write(16'h0040, D6, 3'd2);
    l2_cyc = 1'b1; l2_stb = 1'b1; l2_we = 1'b0; l2_adr = 16'h0040;
    tick();
    chk("hit_young_ack", 128'(l2_ack), 128'd1);
    chk("hit_young_dat", l2_dat_s, D6);
    l2_cyc = 1'b0; l2_stb = 1'b0;
    tick();
    drain_one(16'h0040, D1);
    drain_one(16'h0040, D6);

    // Read miss waits for the in-flight drain, then beats the queued drains
    l2_write(16'h0010, D7, 3'd1);
    l2_write(16'h0020, D8, 3'd2);
    l2_write(16'h0030, DA, 3'd3);
    l2_cyc = 1'b1; l2_stb = 1'b1; l2_we = 1'b0; l2_adr = 16'h0077;
    tick();
    tick();
    chk("miss_wait_ack", 128'(l2_ack), 128'd0);
    chk("miss_wait_mwe", 128'(mem_we), 128'd1);
    chk("miss_wait_madr", 128'(mem_adr), 128'h0010);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("miss_pop_count", 128'(count), 128'd2);
    tick();
    chk("miss_rd_cyc", 128'(mem_cyc), 128'd1);
    chk("miss_rd_we", 128'(mem_we), 128'd0);
    chk("miss_rd_adr", 128'(mem_adr), 128'h0077);
    mem_dat_s = DB; mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("miss_ack", 128'(l2_ack), 128'd1);
    chk("miss_dat", l2_dat_s, DB);
    l2_cyc = 1'b0; l2_stb = 1'b0;
    tick();
    chk("miss_ack_drop", 128'(l2_ack), 128'd0);
    drain_one(16'h0020, D8);
    drain_one(16'h0030, DA);

    // mem_rty hold during a drain, then flush in FIFO order
    l2_write(16'h1000, DC, 3'd1);
    l2_write(16'h2000, D3, 3'd2);
    l2_write(16'h3000, D4, 3'd3);
    mem_rty = 1'b1; mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rty_cyc", 128'(mem_cyc & mem_stb & mem_we), 128'd1);
      chk("rty_adr", 128'(mem_adr), 128'h1000);
      chk("rty_dat", mem_dat_m, DC);
      chk("rty_count", 128'(count), 128'd3);
    end
    mem_rty = 1'b0; mem_ack = 1'b0; flush = 1'b1;
    drain_one(16'h1000, DC);
    chk("flush_mid1", 128'(flush_done), 128'd0);
    drain_one(16'h2000, D3);
    chk("flush_mid2", 128'(flush_done), 128'd0);
    drain_one(16'h3000, D4);
    chk("flush_done", 128'(flush_done), 128'd1);
    chk("flush_count", 128'(count), 128'd0);
    flush = 1'b0;
    tick();
    chk("flush_done_drop", 128'(flush_done), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
